// File: rtl/vga_horizontal_timing_pkg.sv
// Shared 640x480@60 timing constants and line-segment encodings for the horizontal and vertical stages.
package vga_horizontal_timing_pkg;

    localparam int H_ACTIVE_640 = 640;
    localparam int H_FP_640     = 16;
    localparam int H_SYNC_640   = 96;
    localparam int H_BP_640     = 48;
    localparam int H_TOTAL_640  = H_ACTIVE_640 + H_FP_640 + H_SYNC_640 + H_BP_640;

    localparam int V_ACTIVE_480 = 480;
    localparam int V_FP_480     = 10;
    localparam int V_SYNC_480   = 2;
    localparam int V_BP_480     = 33;
    localparam int V_TOTAL_480  = V_ACTIVE_480 + V_FP_480 + V_SYNC_480 + V_BP_480;

    localparam int X_W = 16;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } seg_state_e;

    // Counter width that stays legal for a divide-by-one build.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_horizontal_timing_if.sv
// Run control in, pixel position / sync / strobes out of the horizontal timing stage.
interface vga_horizontal_timing_if
    import vga_horizontal_timing_pkg::*;
;
    logic           run;
    logic [X_W-1:0] x_c;
    logic           pix_en;
    logic           hsync;
    logic           h_active;
    logic           line_start;
    logic           v_enable;

    modport master (
        input  run,
        output x_c, pix_en, hsync, h_active, line_start, v_enable
    );

    modport slave (
        output run,
        input  x_c, pix_en, hsync, h_active, line_start, v_enable
    );
endinterface

// File: rtl/vga_pix_div.sv
// Clock divider producing a one-clk pixel enable every CLK_DIV clks; frozen while run is low.
module vga_pix_div
    import vga_horizontal_timing_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic pix_en
);
    localparam int            DW   = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (run)
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end

    // Gated by rst_n so a divide-by-one build shows no enable while held in reset.
    assign pix_en = rst_n & run & (div_cnt == LAST);
endmodule

// File: rtl/vga_horizontal_timing.sv
// Horizontal line timing: pixel divider, ACTIVE/FRONT/SYNC/BACK segment FSM, x counter and registered decode.
module vga_horizontal_timing
    import vga_horizontal_timing_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_640,
    parameter int H_FP      = H_FP_640,
    parameter int H_SYNC    = H_SYNC_640,
    parameter int H_BP      = H_BP_640,
    parameter int CLK_DIV   = 2,
    parameter bit HSYNC_POL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vga_horizontal_timing_if.master bus
);
    localparam logic [X_W-1:0] H_TOTAL = X_W'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [X_W-1:0] X_LAST  = H_TOTAL - 1'b1;
    localparam logic [X_W-1:0] X_FRONT = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_SYNC  = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] X_BACK  = X_W'(H_ACTIVE + H_FP + H_SYNC);

    logic           pix_en;
    logic [X_W-1:0] x_c, x_nxt;
    logic           x_clr;
    seg_state_e     state, state_nxt;
    logic           hsync_p1, h_active_p1, line_start_p1;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (bus.run),
        .pix_en (pix_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_ACTIVE;
        else if (pix_en)
            state <= state_nxt;
    end

    // Segment boundaries are decided on the x value the next pixel edge will load.
    always_comb begin
        x_nxt     = (x_c == X_LAST) ? '0 : x_c + 1'b1;
        state_nxt = state;
        x_clr     = 1'b0;
        case (state)
            ST_ACTIVE: if (x_nxt == X_FRONT) state_nxt = ST_FRONT;
            ST_FRONT:  if (x_nxt == X_SYNC)  state_nxt = ST_SYNC;
            ST_SYNC:   if (x_nxt == X_BACK)  state_nxt = ST_BACK;
            ST_BACK:   if (x_nxt == '0)      state_nxt = ST_ACTIVE;
            default: begin
                state_nxt = ST_ACTIVE;
                x_clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            x_c <= '0;
        else if (pix_en)
            x_c <= x_clr ? '0 : x_nxt;
    end

    // Stage p1: sync/active decode registered on the same edge as x_c so all three align.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p1      <= ~HSYNC_POL;
            h_active_p1   <= 1'b0;
            line_start_p1 <= 1'b0;
        end else begin
            line_start_p1 <= pix_en && (x_c == X_LAST);
            if (pix_en) begin
                hsync_p1    <= (state_nxt == ST_SYNC) ? HSYNC_POL : ~HSYNC_POL;
                h_active_p1 <= (state_nxt == ST_ACTIVE);
            end
        end
    end

    assign bus.x_c        = x_c;
    assign bus.pix_en     = pix_en;
    assign bus.hsync      = hsync_p1;
    assign bus.h_active   = h_active_p1 & bus.run;
    assign bus.line_start = line_start_p1 & bus.run;
    // Held for the whole last pixel so a downstream divider of any phase sees it.
    assign bus.v_enable   = bus.run & (x_c == X_LAST);
endmodule

// File: tb/tb_vga_horizontal_timing.sv
// Directed checks of the horizontal timing stage: default build plus a CLK_DIV=1, active-high hsync build.
module tb_vga_horizontal_timing;
    logic clk;
    logic rst_n, rst2_n;
    int   n_checks, n_fail;

    vga_horizontal_timing_if bus();
    vga_horizontal_timing_if bus2();

    vga_horizontal_timing dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vga_horizontal_timing #(.CLK_DIV(1), .HSYNC_POL(1'b1)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        bit hs;
        bit ha;
        bit ve;
        bit ls;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic seek(input int x);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (bus.x_c == 16'(x)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("seek_timeout", x, -1);
    endtask

    initial begin
        int cnt_ha, cnt_hs, cnt_ve, cnt_ls, cnt_pe, cnt_bad, steps, max_x;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{1,   1, 1, 0, 0};
        vecs[1]  = '{320, 1, 1, 0, 0};
        vecs[2]  = '{639, 1, 1, 0, 0};
        vecs[3]  = '{640, 1, 0, 0, 0};
        vecs[4]  = '{655, 1, 0, 0, 0};
        vecs[5]  = '{656, 0, 0, 0, 0};
        vecs[6]  = '{700, 0, 0, 0, 0};
        vecs[7]  = '{751, 0, 0, 0, 0};
        vecs[8]  = '{752, 1, 0, 0, 0};
        vecs[9]  = '{799, 1, 0, 1, 0};
        vecs[10] = '{0,   1, 1, 0, 1};
        vecs[11] = '{5,   1, 1, 0, 0};

        // Reset state, with run already high
        rst_n    = 1'b0;
        rst2_n   = 1'b0;
        bus.run  = 1'b1;
        bus2.run = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_x_c",        int'(bus.x_c), 0);
        chk("rst_hsync",      int'(bus.hsync), 1);
        chk("rst_h_active",   int'(bus.h_active), 0);
        chk("rst_pix_en",     int'(bus.pix_en), 0);
        chk("rst_v_enable",   int'(bus.v_enable), 0);
        chk("rst_line_start", int'(bus.line_start), 0);
        rst_n = 1'b1;

        // Table-driven walk through one line
        foreach (vecs[i]) begin
            seek(vecs[i].x);
            chk($sformatf("vec%0d_x%0d_hsync", i, vecs[i].x),      int'(bus.hsync),      int'(vecs[i].hs));
            chk($sformatf("vec%0d_x%0d_h_active", i, vecs[i].x),   int'(bus.h_active),   int'(vecs[i].ha));
            chk($sformatf("vec%0d_x%0d_v_enable", i, vecs[i].x),   int'(bus.v_enable),   int'(vecs[i].ve));
            chk($sformatf("vec%0d_x%0d_line_start", i, vecs[i].x), int'(bus.line_start), int'(vecs[i].ls));
        end

        // Full line, starting on the first clk after the wrap
        seek(0);
        cnt_ha = 0; cnt_hs = 0; cnt_ve = 0; cnt_ls = 0; cnt_pe = 0; max_x = 0;
        for (int i = 0; i < 1600; i++) begin
            if (i > 0) @(negedge clk);
            cnt_ha += int'(bus.h_active);
            cnt_hs += int'(!bus.hsync);
            cnt_ve += int'(bus.v_enable);
            cnt_ls += int'(bus.line_start);
            cnt_pe += int'(bus.pix_en);
            if (int'(bus.x_c) > max_x) max_x = int'(bus.x_c);
        end
        chk("line_h_active_clks",   cnt_ha, 1280);
        chk("line_hsync_low_clks",  cnt_hs, 192);
        chk("line_v_enable_clks",   cnt_ve, 2);
        chk("line_line_start_clks", cnt_ls, 1);
        chk("line_pix_en_clks",     cnt_pe, 800);
        chk("line_max_x",           max_x, 799);

        // End-of-line strobe widths around the wrap
        seek(798);
        cnt_ve = 0; cnt_ls = 0;
        for (int i = 0; i < 8; i++) begin
            cnt_ve += int'(bus.v_enable);
            cnt_ls += int'(bus.line_start);
            @(negedge clk);
        end
        chk("wrap_v_enable_clks",   cnt_ve, 2);
        chk("wrap_line_start_clks", cnt_ls, 1);

        // Freeze at x=400 for 7 clks, then resume
        seek(400);
        bus.run = 1'b0;
        #1;
        chk("freeze_h_active_now", int'(bus.h_active), 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("freeze%0d_x_c", i), int'(bus.x_c), 400);
            chk($sformatf("freeze%0d_strobes", i),
                int'({bus.pix_en, bus.h_active, bus.v_enable, bus.line_start}), 0);
        end
        bus.run = 1'b1;
        #1;
        chk("resume_h_active", int'(bus.h_active), 1);
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            steps++;
            if (bus.x_c != 16'd400) break;
        end
        chk("resume_next_x", int'(bus.x_c), 401);
        chk("resume_clks",   steps, 2);

        // Asynchronous reset mid-SYNC, no clock edge in between
        seek(700);
        chk("pre_rst_hsync", int'(bus.hsync), 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_x_c",      int'(bus.x_c), 0);
        chk("async_rst_hsync",    int'(bus.hsync), 1);
        chk("async_rst_h_active", int'(bus.h_active), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        seek(799);
        chk("pre_rst_v_enable", int'(bus.v_enable), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_v_enable", int'(bus.v_enable), 0);
        chk("async_rst_x_c_799",  int'(bus.x_c), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Divide-by-one, active-high hsync build over three lines
        @(negedge clk);
        chk("d1_rst_hsync",  int'(bus2.hsync), 0);
        chk("d1_rst_pix_en", int'(bus2.pix_en), 0);
        rst2_n   = 1'b1;
        bus2.run = 1'b1;
        cnt_ha = 0; cnt_hs = 0; cnt_ve = 0; cnt_ls = 0; cnt_pe = 0; cnt_bad = 0; max_x = 0;
        for (int i = 1; i <= 2400; i++) begin
            @(negedge clk);
            cnt_ha += int'(bus2.h_active);
            cnt_hs += int'(bus2.hsync);
            cnt_ve += int'(bus2.v_enable);
            cnt_ls += int'(bus2.line_start);
            cnt_pe += int'(bus2.pix_en);
            if (int'(bus2.x_c) > max_x) max_x = int'(bus2.x_c);
            if (int'(bus2.x_c) != (i % 800)) cnt_bad++;
            if (bus2.hsync != (int'(bus2.x_c) >= 656 && int'(bus2.x_c) <= 751)) cnt_bad++;
        end
        chk("d1_pix_en_clks",     cnt_pe, 2400);
        chk("d1_v_enable_clks",   cnt_ve, 3);
        chk("d1_line_start_clks", cnt_ls, 3);
        chk("d1_hsync_high_clks", cnt_hs, 288);
        chk("d1_h_active_clks",   cnt_ha, 1920);
        chk("d1_max_x",           max_x, 799);
        chk("d1_x_hsync_track",   cnt_bad, 0);
        bus2.run = 1'b0;
        #1;
        chk("d1_freeze_pix_en", int'(bus2.pix_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
